// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and helpers for the data memory responder:
//             access mode (funct3) encoding, responder FSM states and
//             the legal-mode check.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Load/store width and extension, encoded exactly as the core's funct3 field
  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } mem_mode_t;

  // Responder sequencing: accept, wait out the wait states, hold the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Encodings 011, 110 and 111 have no meaning for this memory
  function automatic logic is_legal_mode(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: is_legal_mode = 1'b1;
      default:                                  is_legal_mode = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Combinational byte-lane steering. Merges store data into the
//             addressed word, extracts and extends load data, and flags
//             accesses that are not naturally aligned for their width.
//  Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       mode,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] rdata,
  output logic             misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection and mode-dependent merge/extract; unaffected bytes keep old data
  always_comb begin
    merged     = old_word;
    rdata      = '0;
    misaligned = 1'b0;
    sel_byte   = old_word[{lane, 3'b000} +: 8];
    sel_half   = old_word[{lane[1], 4'b0000} +: 16];
    case (mode)
      MODE_B: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        rdata = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      end
      MODE_BU: begin
        rdata = {{(WIDTH-8){1'b0}}, sel_byte};
      end
      MODE_H: begin
        misaligned = lane[0];
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{(WIDTH-16){sel_half[15]}}, sel_half};
      end
      MODE_HU: begin
        misaligned = lane[0];
        rdata = {{(WIDTH-16){1'b0}}, sel_half};
      end
      MODE_W: begin
        misaligned = |lane;
        merged = wdata;
        rdata  = old_word;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Wait-stated data memory for core load/store traffic. One
//             request at a time over valid/ready, served WAIT_CYCLES cycles
//             after acceptance, answered over a valid/ready response channel.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_mode,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One spare code so the counter can hold WAIT_CYCLES itself even when it is 0
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  resp_state_t      state, state_next;
  logic [CW-1:0]    cnt;
  logic             cap_write;
  logic [2:0]       cap_mode;
  logic [WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-3:0] index;
  logic             in_range;
  logic [AW-1:0]    mem_idx;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] extracted;
  logic             misaligned;
  logic             op_error;
  logic             op_fire;
  logic             accept;

  assign index    = cap_addr[WIDTH-1:2];
  assign in_range = index < (WIDTH-2)'(DEPTH);
  assign mem_idx  = cap_addr[2 +: AW];
  // Out-of-range requests never touch the array; feed the aligner a clean zero
  assign old_word = in_range ? mem[mem_idx] : '0;
  assign op_fire  = (state == BUSY) && (cnt == CW'(WAIT_CYCLES));
  assign accept   = req_valid && req_ready;

  // Any error suppresses the write and forces the load result to zero
  assign op_error = !is_legal_mode(cap_mode) || !in_range || misaligned ||
                    (cap_write && ((cap_mode == MODE_BU) || (cap_mode == MODE_HU)));

  mem_lane_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .mode       (cap_mode),
    .lane       (cap_addr[1:0]),
    .old_word   (old_word),
    .wdata      (cap_wdata),
    .merged     (merged),
    .rdata      (extracted),
    .misaligned (misaligned)
  );

  // FSM state register; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        if (op_fire) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait counting, memory update and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_mode  <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_mode  <= req_mode;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= '0;
      end else if ((state == BUSY) && !op_fire) begin
        cnt <= cnt + 1'b1;
      end
      if (op_fire) begin
        rsp_error <= op_error;
        rsp_rdata <= (op_error || cap_write) ? '0 : extracted;
        if (!op_error && cap_write) mem[mem_idx] <= merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed self-checking bench for data_mem_responder with a
//             response scoreboard; exercises a 2-wait-state and a
//             0-wait-state instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_write;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_error2;
  logic [31:0] rsp_rdata2;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_error0;
  logic [31:0] rsp_rdata0;

  // sel=0 talks to the 2-wait-state instance, sel=1 to the 0-wait-state one
  logic        sel;
  logic        cur_ready, cur_valid, cur_error;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? req_ready0 : req_ready2;
  assign cur_valid = sel ? rsp_valid0 : rsp_valid2;
  assign cur_error = sel ? rsp_error0 : rsp_error2;
  assign cur_rdata = sel ? rsp_rdata0 : rsp_rdata2;

  data_mem_responder #(.WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_rdata(rsp_rdata2), .rsp_error(rsp_error2)
  );

  data_mem_responder #(.WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q[$];   // {error, rdata}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid0 = v; else req_valid2 = v;
  endtask

  task automatic set_rdy(input logic v);
    if (sel) rsp_ready0 = v; else rsp_ready2 = v;
  endtask

  task automatic drive(input logic w, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_mode = m; req_addr = a; req_wdata = d;
  endtask

  task automatic push(input logic [31:0] rd, input logic er);
    sb_q.push_back({er, rd});
  endtask

  // Present a request and return just after its accept edge
  task automatic start_req(input logic w, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    drive(w, m, a, d);
    set_valid(1'b1);
    n = 0;
    while (!cur_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_timeout", {31'b0, cur_ready}, 32'd1);
    @(posedge clk); #1;
    set_valid(1'b0);
  endtask

  // Count edges from accept until rsp_valid
  task automatic wait_rsp(input string tag, input int exp_lat);
    int e;
    e = 0;
    while (!cur_valid && e < 50) begin @(posedge clk); #1; e++; end
    chk({tag, "_lat"}, 32'(e), 32'(exp_lat));
  endtask

  // Compare the response with the scoreboard head, then handshake it
  task automatic finish_rsp(input string tag);
    logic [32:0] exp;
    chk({tag, "_sb_nonempty"}, {31'b0, sb_q.size() > 0}, 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h0;
    chk({tag, "_rdata"}, cur_rdata, exp[31:0]);
    chk({tag, "_error"}, {31'b0, cur_error}, {31'b0, exp[32]});
    set_rdy(1'b1);
    @(posedge clk); #1;
    set_rdy(1'b0);
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] m, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er);
    push(exp_rd, exp_er);
    start_req(w, m, a, d);
    wait_rsp(tag, sel ? 1 : 3);
    finish_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    req_valid2 = 1'b0; rsp_ready2 = 1'b0;
    req_valid0 = 1'b0; rsp_ready0 = 1'b0;
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // 1. reset state and word round trip
    chk("rst_ready",  {31'b0, req_ready2}, 32'd1);
    chk("rst_valid",  {31'b0, rsp_valid2}, 32'd0);
    chk("rst_rdata",  rsp_rdata2, 32'h0);
    chk("rst_error",  {31'b0, rsp_error2}, 32'd0);
    chk("rst_ready0", {31'b0, req_ready0}, 32'd1);
    txn("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // 2. byte store, then every load width over the merged word
    txn("sb13",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 1'b0);
    txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);

    // 3. error cases leave memory untouched
    txn("sh11",   1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
    txn("sbu10",  1'b1, 3'b100, 32'h10, 32'h00000011, 32'h0, 1'b1);
    txn("sw12",   1'b1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1'b1);
    txn("lw10c",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    txn("lw400",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    txn("ld011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("lh11",   1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    txn("sw3fc",  1'b1, 3'b010, 32'h3FC, 32'hA5A5A5A5, 32'h0, 1'b0);
    txn("lw3fc",  1'b0, 3'b010, 32'h3FC, 32'h0, 32'hA5A5A5A5, 1'b0);

    // 4. response backpressure with a competing request held meanwhile
    push(32'h80ADBEEF, 1'b0);
    start_req(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp("bp", 3);
    drive(1'b0, 3'b100, 32'h13, 32'h0);
    req_valid2 = 1'b1;
    push(32'h00000080, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, rsp_valid2}, 32'd1);
      chk("bp_rdata", rsp_rdata2, 32'h80ADBEEF);
      chk("bp_ready", {31'b0, req_ready2}, 32'd0);
    end
    finish_rsp("bp");
    chk("bubble_ready", {31'b0, req_ready2}, 32'd1);
    chk("bubble_valid", {31'b0, rsp_valid2}, 32'd0);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    wait_rsp("bp2", 3);
    finish_rsp("bp2");

    // 5. reset during the wait states abandons the store and clears memory
    start_req(1'b1, 3'b010, 32'h20, 32'h12345678);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rm_valid", {31'b0, rsp_valid2}, 32'd0);
    chk("rm_ready", {31'b0, req_ready2}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rm_no_rsp", {31'b0, rsp_valid2}, 32'd0);
    end
    txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    txn("lw10r", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);

    // 6. zero-wait instance: one-edge latency, three-cycle back-to-back rate
    sel = 1'b1;
    txn("z_sw4", 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0);
    txn("z_lb5", 1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFF0, 1'b0);
    drive(1'b0, 3'b010, 32'h4, 32'h0);
    req_valid0 = 1'b1;
    rsp_ready0 = 1'b1;
    repeat (3) push(32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("b2b_valid", {31'b0, rsp_valid0}, {31'b0, (i % 3) == 1});
      if (rsp_valid0 && sb_q.size() > 0) begin
        logic [32:0] exp;
        exp = sb_q.pop_front();
        chk("b2b_rdata", rsp_rdata0, exp[31:0]);
        chk("b2b_error", {31'b0, rsp_error0}, {31'b0, exp[32]});
      end
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
